instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the CPU decode/execute datapath.
//  Replaces the combinational InstrMem lookup with a req/ack memory port.
//  Buffers fetched words plus their PCs in a small prefetch queue.
//  Accepts a taken-branch/jump redirect from downstream.
// PARAMETERS
//  DATA_WIDTH  32  instruction word width
//  ADDR_WIDTH  32  byte-address width
//  DEPTH       4   prefetch queue entries; power of 2, >= 2
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clk          in   1           clock; all state rises on posedge
//  rst          in   1           asynchronous, active-high reset
//  mem_req      out  1           fetch request to instruction memory
//  mem_addr     out  ADDR_WIDTH  word-aligned fetch address
//  mem_ack      in   1           memory returns mem_rdata for the request this cycle
//  mem_rdata    in   DATA_WIDTH  fetched instruction word
//  redirect     in   1           downstream PC change (branch/jump taken)
//  redirect_pc  in   ADDR_WIDTH  new fetch address
//  instr_valid  out  1           queue head is valid
//  instr        out  DATA_WIDTH  queue head instruction
//  instr_pc     out  ADDR_WIDTH  PC of queue head
//  instr_ready  in   1           consumer accepts the head this cycle
// BEHAVIOUR
//  Reset values:
//  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//  - Queue empty, state IDLE.
//  Memory port:
//  - At most one outstanding request.
//  - mem_req and mem_addr stay stable from assertion until the mem_ack cycle.
//  - mem_ack may arrive in the same cycle as mem_req (zero wait).
//  - mem_ack while mem_req=0 is ignored.
//  FSM (registered state):
//  - IDLE: mem_req=0. Go to WAIT when count<DEPTH.
//  - WAIT: mem_req=1, mem_addr=fetch_pc. On mem_ack:
//      push {fetch_pc, mem_rdata}; fetch_pc+=4;
//      stay in WAIT if post-push count<DEPTH, else go to IDLE.
//  - DISCARD: mem_req=1, holding the old address. On mem_ack: drop the data,
//      go to WAIT with the redirected fetch_pc.
//  Consumer transfer and latency:
//  - A transfer occurs when instr_valid && instr_ready; it pops the head.
//  - Pop and push may happen in the same cycle; count is unchanged.
//  - An acked word appears on instr one cycle after mem_ack. No bypass.
//  - Steady state with zero-wait memory: 1 instruction/cycle.
//  Redirect (highest priority):
//  - A consumer transfer in the same cycle still counts.
//  - Then the whole queue is flushed, so instr_valid=0 next cycle.
//  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
//  - From WAIT without mem_ack: go to DISCARD.
//  - From WAIT with mem_ack in the same cycle: drop the data, stay in WAIT.
//  - From IDLE: go to WAIT.
//  - From DISCARD: stay in DISCARD; the latest redirect_pc wins.
//  Boundaries:
//  - Full queue: no request is issued, so an ack always has a free slot.
//  - Empty queue: instr_valid=0; instr/instr_pc hold stale values.
//  - fetch_pc+4 wraps modulo 2^ADDR_WIDTH.
//  - Reset mid-request: mem_req drops immediately; memory must abandon it.
// STRUCTURE
//  Package fetch_pkg:
//  - fetch_state_t enum {IDLE, WAIT, DISCARD}
//  - fetch_entry_t struct {pc, instr}
//  - localparam INSTR_BYTES = 4
//  Sub-module fetch_queue:
//  - Synchronous FIFO of fetch_entry_t with push, pop and flush.
//  - Exposes count.
//  - Flush overrides push.
// TESTING
//  1. Reset, zero-wait memory, instr_ready=1: expect instr_pc 0,4,8,12 on
//     consecutive cycles; first instr_valid 2 cycles after rst falls.
//  2. instr_ready=0, zero-wait memory: exactly DEPTH=4 acks, then mem_req=0.
//     Raise ready: PCs 0..12 drain in order and fetching resumes at 16.
//  3. mem_ack delayed 3 cycles: mem_addr stays stable throughout.
//     One entry is pushed per ack.
//  4. redirect_pc=0x103 asserted while WAIT has no ack:
//     - DISCARD holds mem_addr until ack; that word is dropped.
//     - Next request is to 0x100; first instr_pc=0x100.
//  5. redirect coincident with mem_ack and a consumer transfer:
//     - Transfer counts; acked word is dropped.
//     - Next cycle instr_valid=0; next request addr=redirect_pc.
//  6. Redirect to 0xFFFFFFFC: fetched PCs are 0xFFFFFFFC then 0x0.
//     Assert rst mid-WAIT: mem_req=0 immediately, mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry layout
// and the fixed instruction size in bytes.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    // Default 32-bit entry; the top builds a width-matched copy for its parameters.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding fetched words with their PCs. Flush empties the queue
// and overrides a push in the same cycle.
import fetch_pkg::*;

module fetch_queue #(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    entry_t           mem [DEPTH];

    // NOTE: the storage is reset so the head reads as zero out of reset; at this
    // depth that is cheap and avoids X on instr/instr_pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one req/ack memory fetch at a time, queues
// the returned words with their PCs and handles downstream redirects.
import fetch_pkg::*;

module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      post_push_count;
    logic                  push;
    logic                  pop;
    entry_t                push_data;
    entry_t                head;

    assign next_pc         = fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    assign pop             = instr_valid && instr_ready;
    assign push            = (state == WAIT) && mem_ack && !redirect;
    assign post_push_count = count + CNT_W'(1) - CNT_W'(pop);
    assign push_data       = '{pc: fetch_pc, instr: mem_rdata};

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_target;
            if (state != IDLE && !mem_ack) begin
                // Outstanding request must complete at its original address.
                state <= DISCARD;
            end else begin
                state    <= WAIT;
                mem_req  <= 1'b1;
                mem_addr <= redirect_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < CNT_W'(DEPTH)) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc <= next_pc;
                        if (post_push_count < CNT_W'(DEPTH)) begin
                            mem_addr <= next_pc;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state    <= WAIT;
                        mem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural memory with
// configurable latency and a scoreboard of expected {pc, instr} entries.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        exp_q[$];
    logic [31:0] exp_pc = '0;
    logic        discard = 1'b0;
    int          lat = 0;
    int          wait_cnt = 0;
    logic        req_held = 1'b0;
    logic [31:0] held_addr = '0;
    int          n_push = 0;
    int          n_drop = 0;
    int          n_xfer = 0;
    logic        log_pops = 1'b0;
    logic [31:0] pop_log[$];

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs for the
    // next rising edge and advance the scoreboard to match.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic ack;
        exp_t e;
        @(negedge clk);
        check("valid", instr_valid, exp_q.size() != 0);
        if (mem_req && req_held) check("addr_stable", mem_addr, held_addr);

        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        ack         = mem_req ? (wait_cnt >= lat) : 1'b1;  // spurious acks while idle
        mem_ack     = ack;
        mem_rdata   = ack ? word_at(mem_addr) : '0;

        if (instr_valid && rdy) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.data);
            end
            if (log_pops) pop_log.push_back(instr_pc);
        end

        if (mem_req && ack) begin
            if (discard || redir) begin
                n_drop++;
            end else begin
                check("fetch_addr", mem_addr, exp_pc);
                exp_q.push_back('{pc: mem_addr, data: word_at(mem_addr)});
                exp_pc = exp_pc + 32'd4;
                n_push++;
            end
            discard  = 1'b0;
            wait_cnt = 0;
            req_held = 1'b0;
        end else if (mem_req) begin
            wait_cnt++;
            req_held  = 1'b1;
            held_addr = mem_addr;
        end

        if (redir) begin
            exp_q.delete();
            exp_pc = rpc & ~32'd3;
            if (mem_req && !ack) discard = 1'b1;
        end
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0, '0);
    endtask

    initial begin
        int base_push;
        int base_drop;
        int base_xfer;
        int tries;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // 1: zero-wait memory, consumer always ready
        rst = 1'b0;
        cycle(1'b1, 1'b0, '0);
        check("t1_valid_c1", instr_valid, 1'b0);
        cycle(1'b1, 1'b0, '0);
        check("t1_valid_c2", instr_valid, 1'b1);
        run(4, 1'b1);
        check("t1_throughput", n_xfer, 5);

        // 2: consumer stalled, queue fills to exactly DEPTH then drains in order
        cycle(1'b0, 1'b1, 32'h0);
        base_push = n_push;
        run(10, 1'b0);
        check("t2_acks", n_push - base_push, 4);
        check("t2_req_off", mem_req, 1'b0);
        run(12, 1'b1);

        // 3: three wait states per request
        lat = 3;
        base_push = n_push;
        run(20, 1'b1);
        check("t3_pushes", n_push - base_push, 5);

        // 4: redirect while a request is outstanding
        tries = 0;
        while (!(mem_req && wait_cnt == 1) && tries < 20) begin
            cycle(1'b1, 1'b0, '0);
            tries++;
        end
        check("t4_sync", tries < 20, 1'b1);
        base_drop = n_drop;
        pop_log.delete();
        log_pops = 1'b1;
        cycle(1'b1, 1'b1, 32'h0000_0103);
        pop_log.delete();
        run(20, 1'b1);
        log_pops = 1'b0;
        check("t4_dropped", n_drop - base_drop, 1);
        check("t4_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_DEAD, 32'h100);

        // 5: redirect coincident with ack and a consumer transfer
        lat = 0;
        run(4, 1'b1);
        check("t5_pre_valid", instr_valid, 1'b1);
        base_drop = n_drop;
        base_xfer = n_xfer;
        cycle(1'b1, 1'b1, 32'h0000_0200);
        check("t5_xfer", n_xfer - base_xfer, 1);
        check("t5_dropped", n_drop - base_drop, 1);
        cycle(1'b1, 1'b0, '0);
        check("t5_flushed", instr_valid, 1'b0);
        run(4, 1'b1);

        // 6: address wrap, then reset in the middle of a request
        pop_log.delete();
        log_pops = 1'b1;
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        pop_log.delete();
        run(6, 1'b1);
        log_pops = 1'b0;
        check("t6_wrap0", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
        check("t6_wrap1", pop_log.size() > 1 ? pop_log[1] : 32'hDEAD_DEAD, 32'h0);

        lat = 3;
        tries = 0;
        while (!(mem_req && !mem_ack) && tries < 20) begin
            cycle(1'b0, 1'b0, '0);
            tries++;
        end
        check("t6_sync", tries < 20, 1'b1);
        #1 rst = 1'b1;
        mem_ack = 1'b0;
        #1;
        check("t6_rst_req", mem_req, 1'b0);
        check("t6_rst_addr", mem_addr, 32'h0);
        check("t6_rst_valid", instr_valid, 1'b0);
        exp_q.delete();
        exp_pc   = '0;
        discard  = 1'b0;
        wait_cnt = 0;
        req_held = 1'b0;
        lat      = 0;
        @(negedge clk);
        rst = 1'b0;
        run(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
